// File: rtl/mux_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux_ctrl_pkg
// Shared types and helpers for the 4-input mux round-robin arbiter.
//   N_REQ  : number of requesters sharing the mux
//   SEL_W  : width of the mux select / requester index
//   state_t: arbiter state (IDLE, GRANT)
//   onehot : index -> N_REQ-bit one-hot vector
// -----------------------------------------------------------------------------
package mux_ctrl_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Scans indices last+1, last+2, ...
// (wrapping modulo N_REQ) and returns the first one whose request is high and
// not masked.
//   req   in  N_REQ  request lines
//   mask  in  N_REQ  requests to ignore (1 = ignore)
//   last  in  SEL_W  most recently served index (lowest priority)
//   idx   out SEL_W  winning index (0 when nothing found)
//   found out 1      a winner exists
// -----------------------------------------------------------------------------
module rr_pick
   import mux_ctrl_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] idx,
   output logic             found
);

   logic [N_REQ-1:0] cand;
   logic [SEL_W-1:0] k;

   // NOTE: every signal driven here gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cand  = req & ~mask;
      idx   = '0;
      found = 1'b0;
      k     = '0;
      // SEL_W-bit addition wraps modulo N_REQ; i == N_REQ revisits 'last'
      // itself, which is therefore the lowest-priority candidate.
      for (int i = 1; i <= N_REQ; i++) begin
         k = last + SEL_W'(i);
         if (!found && cand[k]) begin
            idx   = k;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing one 4-input mux between four requesters, with a
// hold limit so one owner cannot monopolise the mux while others wait.
//   clk      in  1      system clock, rising edge
//   rst_n    in  1      asynchronous active-low reset
//   req      in  4      request lines
//   sel      out 2      mux select (granted index; held while idle)
//   gnt      out 4      one-hot grant, zero when idle
//   busy     out 1      a grant is active
//   hold_cnt out CNT_W  cycles the current grant has been held
// All outputs are registered.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
   import mux_ctrl_pkg::*;
#(
   parameter int MAX_HOLD = 8,   // 0 = unlimited tenure
   parameter int CNT_W    = 4    // 2**CNT_W must exceed MAX_HOLD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             busy,
   output logic [CNT_W-1:0] hold_cnt
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   // With no limit the counter still saturates, just at its maximum value.
   localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HOLD_LIM;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [SEL_W-1:0] sel_d;
   logic [N_REQ-1:0] gnt_d;
   logic             busy_d;
   logic [CNT_W-1:0] hold_d;

   logic [N_REQ-1:0] pick_mask;
   logic [SEL_W-1:0] pick_last;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_found;
   logic [N_REQ-1:0] others;
   logic             limit_hit;
   logic             release_w;

   // In GRANT the picker only matters on release, where last becomes the
   // owner and the owner is excluded; in IDLE it uses the stored pointer.
   assign pick_mask = (state_q == GRANT) ? onehot(sel) : '0;
   assign pick_last = (state_q == GRANT) ? sel : last_q;

   rr_pick u_pick (
      .req   (req),
      .mask  (pick_mask),
      .last  (pick_last),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // While granted, sel is the owner index.
   assign others    = req & ~onehot(sel);
   assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && (|others);
   assign release_w = !req[sel] || limit_hit;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sel_d   = sel;
      gnt_d   = gnt;
      busy_d  = busy;
      hold_d  = hold_cnt;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = GRANT;
               sel_d   = pick_idx;
               gnt_d   = onehot(pick_idx);
               busy_d  = 1'b1;
               hold_d  = CNT_W'(1);
            end
         end
         GRANT: begin
            if (release_w) begin
               last_d = sel;
               if (pick_found) begin
                  // Direct handover on the same edge: no idle bubble.
                  sel_d  = pick_idx;
                  gnt_d  = onehot(pick_idx);
                  hold_d = CNT_W'(1);
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
                  hold_d  = '0;
               end
            end else if (hold_cnt != HOLD_SAT) begin
               hold_d = hold_cnt + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= SEL_W'(N_REQ - 1);   // index 0 wins first after reset
         sel      <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         sel      <= sel_d;
         gnt      <= gnt_d;
         busy     <= busy_d;
         hold_cnt <= hold_d;
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Directed stimulus drives req on the falling edge and queues the response
// expected after the next rising edge; a monitor pops and compares shortly
// after each rising edge. Output invariants are checked every falling edge.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       busy;
   logic [3:0] hold_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic [3:0] hold;
   } exp_t;

   exp_t exp_q[$];

   mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .sel      (sel),
      .gnt      (gnt),
      .busy     (busy),
      .hold_cnt (hold_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic [3:0] eh);
      @(negedge clk);
      req = r;
      exp_q.push_back('{gnt: eg, sel: es, busy: eb, hold: eh});
   endtask

   function automatic logic [3:0] oh(input int idx);
      logic [3:0] v;
      v = 4'b0001 << idx;
      return v;
   endfunction

   // Scoreboard monitor.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("gnt",      gnt,      e.gnt);
         check("sel",      sel,      e.sel);
         check("busy",     busy,     e.busy);
         check("hold_cnt", hold_cnt, e.hold);
      end
   end

   // Invariants.
   always @(negedge clk) begin
      check("gnt_onehot0", $onehot0(gnt), 1);
      check("busy_eq_or_gnt", busy, |gnt);
      if (busy) check("gnt_at_sel", gnt[sel], 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      #3 rst_n = 1'b0;
      #1;
      check("rst_gnt",  gnt,      4'b0000);
      check("rst_sel",  sel,      2'd0);
      check("rst_busy", busy,     1'b0);
      check("rst_hold", hold_cnt, 4'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // All four requesting: owners 0,1,2,3,0, eight cycles each, no bubble.
      for (int c = 0; c < 40; c++)
         step(4'b1111, oh((c / 8) % 4), 2'((c / 8) % 4), 1'b1, 4'((c % 8) + 1));
      step(4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0);

      // Single requester 0 for three cycles, then drop.
      step(4'b0001, 4'b0001, 2'd0, 1'b1, 4'd1);
      step(4'b0001, 4'b0001, 2'd0, 1'b1, 4'd2);
      step(4'b0001, 4'b0001, 2'd0, 1'b1, 4'd3);
      step(4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0);

      // last = 0: requester 1 wins before 0; hold limit hands over to 0.
      for (int c = 0; c < 8; c++)
         step(4'b0011, 4'b0010, 2'd1, 1'b1, 4'(c + 1));
      step(4'b0011, 4'b0001, 2'd0, 1'b1, 4'd1);
      step(4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0);

      // Lone owner 2 past the limit: keeps grant, counter saturates at 8.
      for (int c = 0; c < 20; c++)
         step(4'b0100, 4'b0100, 2'd2, 1'b1, (c < 8) ? 4'(c + 1) : 4'd8);
      step(4'b0000, 4'b0000, 2'd2, 1'b0, 4'd0);

      // Owner 1 drops on the same edge requester 3 rises: direct handover.
      step(4'b0010, 4'b0010, 2'd1, 1'b1, 4'd1);
      step(4'b0010, 4'b0010, 2'd1, 1'b1, 4'd2);
      step(4'b1000, 4'b1000, 2'd3, 1'b1, 4'd1);
      step(4'b0000, 4'b0000, 2'd3, 1'b0, 4'd0);

      // Owner 0 drops then re-raises: lowest priority, requester 3 wins.
      step(4'b0001, 4'b0001, 2'd0, 1'b1, 4'd1);
      step(4'b0001, 4'b0001, 2'd0, 1'b1, 4'd2);
      step(4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0);
      step(4'b1001, 4'b1000, 2'd3, 1'b1, 4'd1);
      step(4'b1001, 4'b1000, 2'd3, 1'b1, 4'd2);
      step(4'b1001, 4'b1000, 2'd3, 1'b1, 4'd3);

      // Asynchronous reset between edges while owner 3 holds.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_gnt",  gnt,      4'b0000);
      check("async_rst_busy", busy,     1'b0);
      check("async_rst_hold", hold_cnt, 4'd0);
      check("async_rst_sel",  sel,      2'd0);
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1001;
      exp_q.push_back('{gnt: 4'b0001, sel: 2'd0, busy: 1'b1, hold: 4'd1});
      step(4'b1001, 4'b0001, 2'd0, 1'b1, 4'd2);
      step(4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0);

      waited = 0;
      while (exp_q.size() != 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
